sink_deframer: RTL

//  Receive-side partner of the serial channel source.

---
 rtl/sink_deframer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sink_deframer.sv
// Receive-side TDM deframer: locks to 256-cycle frames of 32 byte-wide slots, rebuilds
// each slot byte MSB first, checks per-slot parity, tracks sync loss and captures one selected slot.
module sink_deframer #(
    parameter int MISS_MAX  = 2,
    parameter bit PAR_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sdata,
    input  logic       sync,
    input  logic       parity,
    input  logic [4:0] sel_slot,
    output logic [7:0] dout,
    output logic [4:0] slot,
    output logic       valid,
    output logic       parity_err,
    output logic [7:0] sel_data,
    output logic       sel_strobe,
    output logic       locked,
    output logic [7:0] perr_cnt
);

    localparam logic [2:0] MISS_LIMIT = 3'(MISS_MAX);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] shreg, shreg_next;
    logic [2:0] miss, miss_next;
    logic [7:0] word;
    logic       slot_done;
    logic       word_perr;
    logic       sel_hit;

    // The sync bit itself is bit 7 of slot 0, so a fresh lock starts one bit into the frame.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        miss_next  = miss;
        slot_done  = 1'b0;
        word       = {shreg[6:0], sdata};
        word_perr  = PAR_CHECK & (^word ^ parity);
        sel_hit    = (cnt[7:3] == sel_slot);

        case (state)
            HUNT: begin
                if (sync) begin
                    state_next = LOCKED;
                    cnt_next   = 8'd1;
                    shreg_next = {7'b0, sdata};
                end
            end
            LOCKED: begin
                shreg_next = word;
                cnt_next   = cnt + 8'd1;
                slot_done  = (cnt[2:0] == 3'd7);
                if (cnt == 8'd0 && sync) begin
                    miss_next = 3'd0;
                end else if (cnt == 8'd0 || sync) begin
                    miss_next = miss + 3'd1;
                    // Dropping lock discards alignment; a stray sync here never relocks directly.
                    if (miss_next >= MISS_LIMIT) begin
                        state_next = HUNT;
                        cnt_next   = 8'd0;
                        shreg_next = 8'd0;
                        miss_next  = 3'd0;
                    end
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
            cnt   <= 8'd0;
            shreg <= 8'd0;
            miss  <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
            miss  <= miss_next;
        end
    end

    // A slot completing in the same cycle as a lock drop is still reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= 8'd0;
            slot       <= 5'd0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            sel_data   <= 8'd0;
            sel_strobe <= 1'b0;
            perr_cnt   <= 8'd0;
        end else begin
            valid      <= slot_done;
            sel_strobe <= slot_done && sel_hit;
            if (slot_done) begin
                dout       <= word;
                slot       <= cnt[7:3];
                parity_err <= word_perr;
                if (word_perr && perr_cnt != 8'hFF) begin
                    perr_cnt <= perr_cnt + 8'd1;
                end
                if (sel_hit) begin
                    sel_data <= word;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
